// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: mode encodings, base-op enum and mode decoder
// shared by the logic_gate_pipe reduction datapath.
package logic_gate_pkg;

   localparam logic [2:0] MODE_AND  = 3'd0;
   localparam logic [2:0] MODE_NAND = 3'd1;
   localparam logic [2:0] MODE_OR   = 3'd2;
   localparam logic [2:0] MODE_NOR  = 3'd3;
   localparam logic [2:0] MODE_XOR  = 3'd4;
   localparam logic [2:0] MODE_XNOR = 3'd5;
   localparam logic [2:0] MODE_LAST = 3'd5;

   typedef enum logic [1:0] {
      BASE_AND,
      BASE_OR,
      BASE_XOR
   } base_e;

   typedef struct packed {
      base_e base;
      logic  invert;
      logic  err;
   } op_t;

   // Reserved modes decode to a harmless XOR with no inversion;
   // the err flag forces the final result to zero downstream.
   function automatic op_t decode_mode(input logic [2:0] mode);
      op_t op;
      op.base   = BASE_XOR;
      op.invert = 1'b0;
      op.err    = 1'b0;
      unique case (1'b1)
         (mode == MODE_AND),
         (mode == MODE_NAND): begin
            op.base   = BASE_AND;
            op.invert = mode[0];
         end
         (mode == MODE_OR),
         (mode == MODE_NOR): begin
            op.base   = BASE_OR;
            op.invert = mode[0];
         end
         (mode == MODE_XOR),
         (mode == MODE_XNOR): begin
            op.base   = BASE_XOR;
            op.invert = mode[0];
         end
         default: begin
            op.err = 1'b1;
         end
      endcase
      return op;
   endfunction

endpackage

// File: rtl/logic_gate_reduce.sv
// logic_gate_reduce: combinational masked reduction of N operands.
// Ports: data_i (N*W operands), mask_i, base_i -> result_o (W bits).
module logic_gate_reduce
   import logic_gate_pkg::*;
#(
   parameter int N_INPUTS = 8,
   parameter int WIDTH    = 1
) (
   input  logic [N_INPUTS*WIDTH-1:0] data_i,
   input  logic [N_INPUTS-1:0]       mask_i,
   input  base_e                     base_i,
   output logic [WIDTH-1:0]          result_o
);

   logic [WIDTH-1:0] ident;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] opnd;

   // Masked operands become the identity of the base op so they
   // leave the accumulator untouched.
   always_comb begin
      ident = (base_i == BASE_AND) ? '1 : '0;
      acc   = ident;
      opnd  = ident;
      for (int k = 0; k < N_INPUTS; k++) begin
         opnd = mask_i[k] ? data_i[k*WIDTH +: WIDTH] : ident;
         unique case (1'b1)
            (base_i == BASE_AND): acc = acc & opnd;
            (base_i == BASE_OR):  acc = acc | opnd;
            default:              acc = acc ^ opnd;
         endcase
      end
      result_o = acc;
   end

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: 2-stage valid/ready masked gate reduction.
// Ports: clk, rst (sync high), in_valid/in_ready/in_data/in_mask/mode,
// out_valid/out_ready/out_data/out_mode_err; out_count only when
// LOGIC_GATE_CNT_EN is defined (saturating delivered-result count).
module logic_gate_pipe
   import logic_gate_pkg::*;
#(
   parameter int N_INPUTS = 8,
   parameter int WIDTH    = 1,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_INPUTS*WIDTH-1:0] in_data,
   input  logic [N_INPUTS-1:0]       in_mask,
   input  logic [2:0]                mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
`ifdef LOGIC_GATE_CNT_EN
   output logic [CNT_W-1:0]          out_count,
`endif
   output logic                      out_mode_err
);

   if (N_INPUTS < 2 || N_INPUTS > 32) begin : g_bad_n
      $error("N_INPUTS must be 2..32");
   end
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_w
      $error("WIDTH must be 1..64");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("CNT_W must be >= 1");
   end

   op_t              op;
   logic [WIDTH-1:0] red;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_base_q,  s1_base_d;
   logic             s1_inv_q,   s1_inv_d;
   logic             s1_err_q,   s1_err_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             out_err_q,   out_err_d;

   logic             s2_adv;
   logic             s1_adv;
   logic             in_xfer;

   assign op = decode_mode(mode);

   logic_gate_reduce #(
      .N_INPUTS (N_INPUTS),
      .WIDTH    (WIDTH)
   ) u_reduce (
      .data_i   (in_data),
      .mask_i   (in_mask),
      .base_i   (op.base),
      .result_o (red)
   );

   assign s2_adv   = !out_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_xfer  = in_valid && s1_adv;
   assign in_ready = s1_adv;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_base_d   = s1_base_q;
      s1_inv_d    = s1_inv_q;
      s1_err_d    = s1_err_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;

      if (s1_adv) begin
         s1_valid_d = in_valid;
      end
      if (in_xfer) begin
         s1_base_d = red;
         s1_inv_d  = op.invert;
         s1_err_d  = op.err;
      end

      // Payload only moves with a valid bundle, so a drained
      // output keeps its last value instead of picking up junk.
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = s1_err_q ? '0
                       : s1_base_q ^ {WIDTH{s1_inv_q}};
            out_err_d  = s1_err_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_base_q   <= '0;
         s1_inv_q    <= 1'b0;
         s1_err_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_base_q   <= s1_base_d;
         s1_inv_q    <= s1_inv_d;
         s1_err_q    <= s1_err_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_mode_err = out_err_q;

`ifdef LOGIC_GATE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid_q && out_ready && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_count = cnt_q;
`endif

endmodule
